// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display driver.
// Scan state encoding, display word layout and all-off patterns.
package seg_pkg;

   typedef enum logic {
      S_BLANK = 1'b0,
      S_DRIVE = 1'b1
   } state_e;

   typedef struct packed {
      logic [3:0]  dp;
      logic [15:0] data;
   } disp_t;

   localparam logic [6:0] SEG_OFF    = 7'h7F;
   localparam logic [3:0] ANODES_OFF = 4'hF;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment pattern.
module hex_to_seg (
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = 7'h7F;
      case (nibble_i)
         4'h0: seg_o = 7'h40;
         4'h1: seg_o = 7'h79;
         4'h2: seg_o = 7'h24;
         4'h3: seg_o = 7'h30;
         4'h4: seg_o = 7'h19;
         4'h5: seg_o = 7'h12;
         4'h6: seg_o = 7'h02;
         4'h7: seg_o = 7'h78;
         4'h8: seg_o = 7'h00;
         4'h9: seg_o = 7'h10;
         4'hA: seg_o = 7'h08;
         4'hB: seg_o = 7'h03;
         4'hC: seg_o = 7'h46;
         4'hD: seg_o = 7'h21;
         4'hE: seg_o = 7'h06;
         4'hF: seg_o = 7'h0E;
         default: seg_o = 7'h7F;
      endcase
   end

endmodule

// File: rtl/seven_seg_driver.sv
// Time-multiplexed 4-digit common-anode display driver with dead-time
// between digits and frame-synchronous data swap.
module seven_seg_driver
   import seg_pkg::*;
#(
   parameter int DIGIT_CYCLES = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] data_in,
   input  logic [3:0]  dp_in,
   input  logic        load,
   input  logic        blank,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   localparam int MAX_CYCLES = max_int(DIGIT_CYCLES, BLANK_CYCLES);
   localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   state_e        state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   disp_t         pend_q, pend_d;
   disp_t         disp_q, disp_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic          frame_done_q, frame_done_d;
   logic [3:0]    nibble;
   logic [6:0]    seg_w;
   disp_t         load_val;

   assign load_val = disp_t'({dp_in, data_in});
   assign nibble   = disp_q.data[{idx_q, 2'b00} +: 4];

   hex_to_seg u_hex_to_seg (
      .nibble_i (nibble),
      .seg_o    (seg_w)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_BLANK;
         idx_q   <= 2'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q + CW'(1);
      case (state_q)
         S_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               state_d = S_DRIVE;
               cnt_d   = '0;
            end
         end
         S_DRIVE: begin
            if (cnt_q == DIGIT_LAST) begin
               state_d = S_BLANK;
               idx_d   = idx_q + 2'd1;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_BLANK;
            cnt_d   = '0;
         end
      endcase
   end

   // The registered frame_done marks the swap cycle, so a load seen on the
   // same cycle as the visible pulse goes straight into disp.
   always_comb begin
      an_d = ANODES_OFF;
      if (state_q == S_DRIVE && !blank) begin
         an_d[idx_q] = 1'b0;
      end
      seg_d        = seg_w;
      dp_d         = ~disp_q.dp[idx_q];
      frame_done_d = (state_q == S_DRIVE) && (idx_q == 2'd3) && (cnt_q == DIGIT_LAST);
      pend_d       = load ? load_val : pend_q;
      disp_d       = disp_q;
      if (frame_done_q) begin
         disp_d = load ? load_val : pend_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_q       <= '0;
         disp_q       <= '0;
         an_q         <= ANODES_OFF;
         seg_q        <= SEG_OFF;
         dp_q         <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         pend_q       <= pend_d;
         disp_q       <= disp_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_done = frame_done_q;

endmodule
